// File: rtl/mac_reset_seq.sv
// mac_reset_seq: staggered multi-channel reset sequencer for the 156.25 MHz
// MAC domain. Holds NUM_CH reset outputs high while xaui_reset is asserted,
// then releases channel 0 after HOLD_CYCLES and each following channel
// STAGGER_CYCLES later. In RUN, any channel can be re-reset for HOLD_CYCLES
// through a single-cycle ch_rst_req pulse.
// Build option: define MAC_RESET_LINK_WAIT_EN to gate the release of
// channel 0 on link_ok, and to restart the sequence when link_ok drops for
// two consecutive cycles.
module mac_reset_seq #(
    parameter int NUM_CH         = 4,
    parameter int HOLD_CYCLES    = 6,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic              clk156_25,
    input  logic              xaui_reset,
    input  logic              link_ok,
    input  logic [NUM_CH-1:0] ch_rst_req,
    output logic [NUM_CH-1:0] reset156_25,
    output logic              seq_busy,
    output logic              seq_done
);

    // One-hot sequencer states
    localparam logic [3:0] ST_ASSERT  = 4'b0001;
    localparam logic [3:0] ST_HOLD    = 4'b0010;
    localparam logic [3:0] ST_STAGGER = 4'b0100;
    localparam logic [3:0] ST_RUN     = 4'b1000;

    localparam int SEQ_SPAN = HOLD_CYCLES + (NUM_CH - 1) * STAGGER_CYCLES;
    // Counter value seen on the edge that ends a hold window
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    // Counter value (counted from the channel 0 release) seen on the edge
    // that releases the last channel; only reachable when STAGGER is used
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'((NUM_CH - 1) * STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Reject parameter sets the counters cannot represent
    if (NUM_CH < 1 || NUM_CH > 16 || HOLD_CYCLES < 2 || STAGGER_CYCLES < 0 ||
        CNT_W < 1 || CNT_W > 30 || SEQ_SPAN > (2 ** CNT_W) - 1) begin : g_param_check
        $error("mac_reset_seq: parameter combination out of range");
    end

    logic [3:0]        state, state_nxt;
    logic [CNT_W-1:0]  seq_cnt, seq_cnt_nxt;
    logic [NUM_CH-1:0] rst_nxt;
    logic [NUM_CH-1:0] soft_act, soft_act_nxt;
    logic [CNT_W-1:0]  soft_cnt     [NUM_CH];
    logic [CNT_W-1:0]  soft_cnt_nxt [NUM_CH];
    logic              hold_done;
    logic              link_drop;

`ifdef MAC_RESET_LINK_WAIT_EN
    logic [CNT_W-1:0] link_cnt;
    logic             link_low_q;

    // Track consecutive high samples of link_ok and the previous low sample
    always_ff @(posedge clk156_25) begin
        if (xaui_reset) begin
            link_cnt   <= '0;
            link_low_q <= 1'b0;
        end else begin
            link_low_q <= ~link_ok;
            if (!link_ok)
                link_cnt <= '0;
            else if (link_cnt != CNT_W'(HOLD_CYCLES))
                link_cnt <= link_cnt + CNT_W'(1);
        end
    end

    assign hold_done = (seq_cnt == HOLD_LAST) && (link_cnt == CNT_W'(HOLD_CYCLES));
    assign link_drop = link_low_q && !link_ok && (state == ST_STAGGER || state == ST_RUN);
`else
    // link_ok is deliberately not used in this build
    logic unused_link_ok;
    assign unused_link_ok = link_ok;
    assign hold_done      = (seq_cnt == HOLD_LAST);
    assign link_drop      = 1'b0;
`endif

    assign seq_busy = (state != ST_RUN);

    // Next-state, release schedule and soft-reset windows
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nxt    = state;
        seq_cnt_nxt  = seq_cnt;
        rst_nxt      = reset156_25;
        soft_act_nxt = soft_act;
        soft_cnt_nxt = soft_cnt;

        case (state)
            ST_ASSERT: begin
                state_nxt   = ST_HOLD;
                seq_cnt_nxt = '0;
                rst_nxt     = '1;
            end
            ST_HOLD: begin
                if (hold_done) begin
                    // Counter restarts so the stagger is measured from this release
                    seq_cnt_nxt = '0;
                    if (NUM_CH == 1 || STAGGER_CYCLES == 0) begin
                        rst_nxt   = '0;
                        state_nxt = ST_RUN;
                    end else begin
                        rst_nxt[0] = 1'b0;
                        state_nxt  = ST_STAGGER;
                    end
                end else if (seq_cnt != HOLD_LAST) begin
                    seq_cnt_nxt = seq_cnt + CNT_W'(1);
                end
            end
            ST_STAGGER: begin
                if (seq_cnt != CNT_MAX)
                    seq_cnt_nxt = seq_cnt + CNT_W'(1);
                for (int k = 1; k < NUM_CH; k++) begin
                    if (int'(seq_cnt) == k * STAGGER_CYCLES - 1)
                        rst_nxt[k] = 1'b0;
                end
                if (seq_cnt == STAG_LAST)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (ch_rst_req[k]) begin
                        // A new request (re)starts the window from this edge
                        soft_act_nxt[k] = 1'b1;
                        soft_cnt_nxt[k] = '0;
                        rst_nxt[k]      = 1'b1;
                    end else if (soft_act[k]) begin
                        if (soft_cnt[k] == HOLD_LAST) begin
                            soft_act_nxt[k] = 1'b0;
                            soft_cnt_nxt[k] = '0;
                            rst_nxt[k]      = 1'b0;
                        end else begin
                            soft_cnt_nxt[k] = soft_cnt[k] + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_nxt   = ST_ASSERT;
                seq_cnt_nxt = '0;
                rst_nxt     = '1;
            end
        endcase

        // Losing link behaves like a one-cycle xaui_reset pulse
        if (link_drop) begin
            state_nxt    = ST_ASSERT;
            seq_cnt_nxt  = '0;
            rst_nxt      = '1;
            soft_act_nxt = '0;
            for (int k = 0; k < NUM_CH; k++)
                soft_cnt_nxt[k] = '0;
        end
    end

    // Sequencer registers with synchronous xaui_reset
    always_ff @(posedge clk156_25) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (xaui_reset) begin
            state       <= ST_ASSERT;
            seq_cnt     <= '0;
            reset156_25 <= '1;
            soft_act    <= '0;
            seq_done    <= 1'b0;
            // NOTE: the soft counter array is reset explicitly; it is a few flops, not a RAM.
            for (int k = 0; k < NUM_CH; k++)
                soft_cnt[k] <= '0;
        end else begin
            state       <= state_nxt;
            seq_cnt     <= seq_cnt_nxt;
            reset156_25 <= rst_nxt;
            soft_act    <= soft_act_nxt;
            soft_cnt    <= soft_cnt_nxt;
            seq_done    <= (reset156_25 == '0);
        end
    end

endmodule

// File: doc/mac_reset_seq.md
Name: mac_reset_seq

Overview:
- Parametrised successor to the single-output MAC reset stretcher.
- Generates NUM_CH synchronous, active-high reset outputs in the 156.25 MHz domain from the XAUI reset, releasing them in staggered order.
- Also supports per-channel soft reset requests, and optionally waits for link status before releasing.
- Sits between the XAUI core reset and the per-port MAC/datapath blocks.

Parameters:
- NUM_CH, 4, number of reset outputs (1..16).
- HOLD_CYCLES, 6, cycles from the first sampled-low xaui_reset to release of channel 0; also the per-channel soft reset length (>=2).
- STAGGER_CYCLES, 4, extra cycles between release of channel k and channel k+1 (0 = all channels release together).
- CNT_W, 8, sequence counter width; must hold HOLD_CYCLES+(NUM_CH-1)*STAGGER_CYCLES.

Ports:
- clk156_25  in  1  156.25 MHz clock; only clock.
- xaui_reset  in  1  synchronous, active-high reset; also the sequence trigger.
- link_ok  in  1  XAUI lane-alignment status; used only with MAC_RESET_LINK_WAIT_EN.
- ch_rst_req  in  NUM_CH  per-channel soft reset request, single-cycle pulse per bit.
- reset156_25  out  NUM_CH  per-channel reset, active-high, registered.
- seq_busy  out  1  high while the global sequence is running (not in RUN).
- seq_done  out  1  high when every reset156_25 bit is 0.

Behaviour:
- Clock and reset: one clock, clk156_25. xaui_reset is synchronous and active-high. No asynchronous logic.
- Reset values (xaui_reset high, and initial values):
  - reset156_25 = all ones
  - seq_busy = 1
  - seq_done = 0
  - FSM = ASSERT
  - counters = 0
  - per-channel soft counters = 0
- FSM states: ASSERT, HOLD, STAGGER, RUN. Encoding is one-hot.
- ASSERT: first edge with xaui_reset low (edge E0) moves to HOLD and clears the counter. All outputs stay 1.
- HOLD: counter increments each edge.
  - When the counter reaches HOLD_CYCLES-1, reset156_25[0] is cleared at edge E0+HOLD_CYCLES.
  - If NUM_CH=1, go to RUN; otherwise go to STAGGER.
  - With NUM_CH=1 and no feature macro, this timing equals the legacy block: output low at the 7th edge after deassertion.
- STAGGER: channel k is cleared at edge E0+HOLD_CYCLES+k*STAGGER_CYCLES.
  - With STAGGER_CYCLES=0, all channels clear at E0+HOLD_CYCLES.
  - After the last channel clears, go to RUN.
- RUN:
  - seq_busy=0.
  - seq_done is registered: high the cycle after all bits are 0.
  - Terminal state until xaui_reset.
- Soft reset in RUN: ch_rst_req[k]=1 sampled at edge T →
  - reset156_25[k]=1 from edge T through edge T+HOLD_CYCLES-1, cleared at edge T+HOLD_CYCLES;
  - seq_done=0 from edge T+1;
  - other channels unaffected.
- Repeated ch_rst_req[k] while channel k is in soft hold restarts its count from the new request edge.
- Simultaneous requests on several bits: each channel is handled independently with an identical window.
- ch_rst_req outside RUN is ignored; the channel is already in reset or about to be sequenced.
- xaui_reset asserted at any time, including mid-sequence or mid soft hold:
  - all outputs go to 1 on the same edge;
  - all counters clear;
  - the sequence restarts from ASSERT.
- Counters saturate and never wrap. An out-of-range parameter combination is a synthesis-time error via a generate-time check.

Optional Feature:
- Macro: MAC_RESET_LINK_WAIT_EN.
- Defined:
  - HOLD does not complete until link_ok has been high for HOLD_CYCLES consecutive cycles. The consecutive-high counter resets on any low cycle.
  - Channel 0 releases on the edge after the counter completes.
  - link_ok falling while in STAGGER or RUN for 2 consecutive cycles forces all channels back to 1 and restarts the FSM at ASSERT, as if xaui_reset had pulsed.
- Undefined: link_ok is ignored (port kept, unconnected internally), and timing is exactly as above.

Test Plan:
- Defaults, xaui_reset high 10 cycles then low at E0 → reset156_25 = 4'b1111 until E0+6; then bits clear at E0+6, +10, +14, +18; seq_busy falls at E0+18; seq_done rises at E0+19.
- NUM_CH=1, HOLD_CYCLES=6 → single output falls exactly 6 edges after the first sampled-low xaui_reset (legacy timing).
- In RUN, ch_rst_req=4'b0100 pulse at T → reset156_25[2] high T..T+5 and low at T+6; bits 0, 1 and 3 stay 0; seq_done low T+1..T+6 and high at T+7.
- xaui_reset pulsed 1 cycle at E0+8 (mid-stagger) → all bits 1 at that edge; full sequence restarts; channel 0 clears 6 edges after the pulse drops.
- ch_rst_req[1] pulsed at T and again at T+3 → bit 1 stays high until T+9.
- MAC_RESET_LINK_WAIT_EN: link_ok low until E0+20, then high → bit 0 clears at E0+26. Later link_ok low for 2 cycles in RUN → all bits 1 and the sequence restarts.
